parity_scan_engine: RTL
=======================

Name: parity_scan_engine

Overview:
Parametrised memory-integrity scanner that walks an external synchronous-read memory of 2^ADDR_W words, checks each word's stored parity bit against recomputed parity, and reports per-word match, an error count and the first failing address. Replaces the free-running counter + bank mux + combinational checker arrangement with a start/stop controlled FSM, pipelined check stage, single-pass or continuous modes, and selectable even/odd parity. Sits between the test/control logic and any data+parity memory.

Parameters:
DATA_W, 8, data word width in bits (>=2)
ADDR_W, 4, address width; depth = 2^ADDR_W words
ERR_W, 8, error counter width
PARITY_ODD, 0, 0 = even parity (stored bit = XOR of data); 1 = odd parity (stored bit = ~XOR of data)

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin scan (sampled in IDLE only)
stop  in  1  end scan early (sampled in SCAN only)
mode  in  1  0 = single pass, 1 = continuous wrap; sampled with start
mem_rd_en  out  1  read strobe to memory
mem_addr  out  ADDR_W  read address
mem_data  in  DATA_W  read data, valid cycle after mem_rd_en
mem_parity  in  1  stored parity, valid cycle after mem_rd_en
chk_valid  out  1  check result valid this cycle
chk_addr  out  ADDR_W  address of checked word
chk_data  out  DATA_W  checked word
detect  out  1  recomputed parity (PARITY_ODD applied)
match  out  1  1 = mem_parity equals detect
err_count  out  ERR_W  mismatches since last start, saturating
first_err_valid  out  1  a mismatch has been seen since last start
first_err_addr  out  ADDR_W  address of first mismatch
busy  out  1  high in SCAN and DRAIN
done  out  1  one-cycle pulse on scan completion

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; pipeline valid bits cleared, in-flight reads discarded. Reset mid-scan aborts with no done pulse.
- FSM states IDLE, SCAN, DRAIN, DONE.
- IDLE: start=1 -> SCAN next cycle; latch mode; clear err_count, first_err_valid, first_err_addr, address counter=0. stop ignored.
- SCAN: mem_rd_en=1 every cycle, mem_addr = counter, counter +1 per cycle.
  - mode 0: after issuing address 2^ADDR_W-1 -> DRAIN.
  - mode 1: counter wraps 2^ADDR_W-1 -> 0, stays in SCAN.
  - stop=1: read for current address is still issued this cycle, then -> DRAIN. stop has priority over wrap/end.
  - start ignored while busy.
- DRAIN: mem_rd_en=0; exactly 2 cycles for outstanding checks to retire; -> DONE.
- DONE: done=1 for one cycle, busy=0; -> IDLE. Results (err_count, first_err_*) hold until next start or reset.
- Pipeline: read issued cycle n; stage 1 registers addr alongside; memory data sampled end of cycle n+1; chk_valid/chk_addr/chk_data/detect/match valid cycle n+2. chk_* hold last value when chk_valid=0.
- detect = XOR(mem_data) XOR PARITY_ODD; match = (mem_parity == detect).
- On chk_valid and match=0: err_count +1, saturates at 2^ERR_W-1; if first_err_valid=0, set it and capture chk_addr.
- Single pass, DEPTH=16: start at cycle 0 -> rd_en cycles 1..16, chk_valid cycles 3..18, done cycle 19.

Optional Feature:
PSCAN_ERR_INJECT_EN: when defined, adds inputs inj_en (1) and inj_addr (ADDR_W); when inj_en=1, data bit 0 is inverted in the check stage for the word at inj_addr before parity recomputation (chk_data shows the inverted word). When undefined, ports absent and data checked unmodified.

Test Plan:
- Single pass, even parity, memory data=addr*0x11, parity correct everywhere -> 16 chk_valid pulses cycles 3..18, match=1 all, err_count=0, first_err_valid=0, done pulse cycle 19.
- Same memory with parity bit flipped at addresses 5 and 9 -> match=0 at chk_addr 5 and 9, err_count=2, first_err_addr=5.
- Continuous mode, stop asserted at the cycle mem_addr=3 of second lap -> reads end at addr 3, 20 total checks, DRAIN 2 cycles, done one cycle later.
- ERR_W=2, all 16 parities wrong -> err_count saturates at 3, first_err_addr=0.
- Reset asserted mid-scan at mem_addr=7 -> next cycle all outputs 0, IDLE, no done; new start gives clean pass from addr 0.
- PARITY_ODD=1 with even-parity memory -> every word mismatches, err_count=16 (ERR_W=8); with PSCAN_ERR_INJECT_EN, inj_addr=4 on correct memory -> only addr 4 fails, err_count=1.

Source files
------------

// File: rtl/parity_scan_engine_if.sv
// Memory read bus between the parity scan engine (master) and a data+parity memory (slave).
interface parity_scan_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_parity;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_data,
    input  mem_parity
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_data,
    output mem_parity
  );
endinterface

// File: rtl/parity_scan_engine.sv
// Walks a synchronous-read data+parity memory, checks each word's parity and tracks errors.
// Optional error injection in the check stage is enabled by defining PSCAN_ERR_INJECT_EN.
module parity_scan_engine #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        mode,
  parity_scan_engine_if.master        mem,
  output logic                        chk_valid,
  output logic [ADDR_W-1:0]           chk_addr,
  output logic [DATA_W-1:0]           chk_data,
  output logic                        detect,
  output logic                        match,
  output logic [ERR_W-1:0]            err_count,
  output logic                        first_err_valid,
  output logic [ADDR_W-1:0]           first_err_addr,
  output logic                        busy,
  output logic                        done
`ifdef PSCAN_ERR_INJECT_EN
  ,
  input  logic                        inj_en,
  input  logic [ADDR_W-1:0]           inj_addr
`endif
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr  = '1;
  localparam logic [ERR_W-1:0]  ErrMax    = '1;
  localparam logic              ParityOdd = (PARITY_ODD != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              drain_q, drain_d;
  logic              clear_res;
  logic              rd_en;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] inj_mask;
  logic [DATA_W-1:0] chk_data_c;
  logic              detect_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    drain_d   = drain_q;
    clear_res = 1'b0;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StScan;
          mode_d    = mode;
          cnt_d     = '0;
          clear_res = 1'b1;
        end
      end
      StScan: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        cnt_d = cnt_q + ADDR_W'(1);
        // Stop wins over both end-of-pass and wrap; the current read still issues.
        if (stop || (!mode_q && (cnt_q == LastAddr))) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        busy    = 1'b1;
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      drain_q <= drain_d;
    end
  end

  assign mem.mem_rd_en = rd_en;
  assign mem.mem_addr  = cnt_q;

  // Stage 1 carries the address while the memory produces its data.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      s1_addr_q  <= cnt_q;
    end
  end

`ifdef PSCAN_ERR_INJECT_EN
  assign inj_mask = (inj_en && (s1_addr_q == inj_addr)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
`else
  assign inj_mask = '0;
`endif

  assign chk_data_c = mem.mem_data ^ inj_mask;
  assign detect_c   = (^chk_data_c) ^ ParityOdd;

  always_ff @(posedge clock) begin
    if (reset) begin
      chk_valid <= 1'b0;
      chk_addr  <= '0;
      chk_data  <= '0;
      detect    <= 1'b0;
      match     <= 1'b0;
    end else begin
      chk_valid <= s1_valid_q;
      if (s1_valid_q) begin
        chk_addr <= s1_addr_q;
        chk_data <= chk_data_c;
        detect   <= detect_c;
        match    <= (mem.mem_parity == detect_c);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_res) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (chk_valid && !match) begin
      if (err_count != ErrMax) err_count <= err_count + ERR_W'(1);
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= chk_addr;
      end
    end
  end

endmodule
